control_sequencer: RTL and testbench

//  Moore-style control-step sequencer for the Mini SRC datapath. Walks fetch (T0-T2)
//  and per-class execute steps, and drives the datapath strobes.
//  Its Gra/Grb/Grc/Rin/Rout/BAout outputs feed the register select-and-encode stage,

---
 rtl/control_sequencer_pkg.sv | 40 ++++
 rtl/control_sequencer_if.sv | 25 ++
 rtl/control_sequencer_instr_class_decode.sv | 26 ++
 rtl/control_sequencer.sv | 125 ++++++++++++
 tb/tb_control_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared opcode map, control-step encoding and instruction-class record
// for the Mini SRC control sequencer.
package control_sequencer_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  typedef struct packed {
    logic alu3;
    logic imm;
    logic ldi;
    logic ld;
    logic st;
    logic nop;
    logic halt;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/memory status in, control strobes out.
interface control_sequencer_if #(parameter int OPCODE_W = 5);
  logic [31:0]         IR;
  logic                mem_ready;
  logic                PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin;
  logic                MDRin, MDRout, IRin, Read, Write, Cout;
  logic                Gra, Grb, Grc, Rin, Rout, BAout;
  logic [OPCODE_W-1:0] alu_op;
  logic                run;
  logic                illegal;

  modport master (
    input  IR, mem_ready,
    output PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin,
           MDRin, MDRout, IRin, Read, Write, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, illegal
  );

  modport slave (
    output IR, mem_ready,
    input  PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin,
           MDRin, MDRout, IRin, Read, Write, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, illegal
  );
endinterface

// File: rtl/control_sequencer_instr_class_decode.sv
// Opcode -> one-hot instruction class; anything outside the map is illegal.
module instr_class_decode
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output iclass_t             cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  cls_o.alu3    = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:         cls_o.imm     = 1'b1;
      OP_LDI:                           cls_o.ldi     = 1'b1;
      OP_LD:                            cls_o.ld      = 1'b1;
      OP_ST:                            cls_o.st      = 1'b1;
      OP_NOP:                           cls_o.nop     = 1'b1;
      OP_HALT:                          cls_o.halt    = 1'b1;
      default:                          cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control-step sequencer: fetch T0-T2, class-dependent execute T3-T7,
// strobes decoded from the current step (read-step MDRin also gated by mem_ready).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  state_e              state_q, state_d;
  iclass_t             cls_now, cls_q, cls;
  logic [OPCODE_W-1:0] op_now, op_q;

  assign op_now = bus.IR[31 -: OPCODE_W];

  instr_class_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode_i (op_now),
    .cls_o    (cls_now)
  );

  // Class is taken live from IR in T3 and frozen for the remaining steps.
  assign cls = (state_q == ST_T3) ? cls_now : cls_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_RST;
      cls_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T3) begin
        cls_q <= cls_now;
        op_q  <= op_now;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = bus.mem_ready ? ST_T2 : ST_T1;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (cls.alu3 | cls.imm | cls.ldi | cls.ld | cls.st) state_d = ST_T4;
        else if (cls.halt)                                  state_d = ST_HALT;
        else                                                state_d = ST_T0;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (cls.ld | cls.st) ? ST_T6 : ST_T0;
      ST_T6:   state_d = (cls.ld && !bus.mem_ready) ? ST_T6 : ST_T7;
      ST_T7:   state_d = (cls.st && !bus.mem_ready) ? ST_T7 : ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    bus.PCout   = 1'b0; bus.MARin  = 1'b0; bus.IncPC = 1'b0; bus.PCin  = 1'b0;
    bus.Zin     = 1'b0; bus.Zlowout = 1'b0; bus.Yin  = 1'b0; bus.MDRin = 1'b0;
    bus.MDRout  = 1'b0; bus.IRin   = 1'b0; bus.Read  = 1'b0; bus.Write = 1'b0;
    bus.Cout    = 1'b0; bus.Gra    = 1'b0; bus.Grb   = 1'b0; bus.Grc   = 1'b0;
    bus.Rin     = 1'b0; bus.Rout   = 1'b0; bus.BAout = 1'b0;
    bus.alu_op  = '0;
    bus.illegal = 1'b0;
    bus.run     = (state_q != ST_RST) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1;
        bus.MDRin   = bus.mem_ready;
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      ST_T3: begin
        if (cls.alu3 | cls.imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (cls.ldi | cls.ld | cls.st) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end
        bus.illegal = cls.illegal;
      end
      ST_T4: begin
        bus.Zin = 1'b1;
        if (cls.alu3) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.alu_op = op_q;
        end else if (cls.imm) begin
          bus.Cout = 1'b1; bus.alu_op = op_q;
        end else begin
          bus.Cout = 1'b1; bus.alu_op = OPCODE_W'(OP_ADD);
        end
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (cls.ld | cls.st) bus.MARin = 1'b1;
        else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      ST_T6: begin
        if (cls.ld) begin
          bus.Read = 1'b1; bus.MDRin = bus.mem_ready;
        end else begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end
      end
      ST_T7: begin
        if (cls.ld) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed walk through fetch and each instruction class with hand-computed strobes.
module tb_control_sequencer;

  logic clock;
  logic clear;
  int   num_cmp = 0;
  int   num_err = 0;

  control_sequencer_if #(.OPCODE_W(5)) bus ();

  control_sequencer #(.OPCODE_W(5)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  localparam logic [18:0] PCOUT  = 19'h40000;
  localparam logic [18:0] MARIN  = 19'h20000;
  localparam logic [18:0] INCPC  = 19'h10000;
  localparam logic [18:0] PCIN   = 19'h08000;
  localparam logic [18:0] ZIN    = 19'h04000;
  localparam logic [18:0] ZLO    = 19'h02000;
  localparam logic [18:0] YIN    = 19'h01000;
  localparam logic [18:0] MDRIN  = 19'h00800;
  localparam logic [18:0] MDROUT = 19'h00400;
  localparam logic [18:0] IRIN   = 19'h00200;
  localparam logic [18:0] RD     = 19'h00100;
  localparam logic [18:0] WR     = 19'h00080;
  localparam logic [18:0] COUT   = 19'h00040;
  localparam logic [18:0] GRA    = 19'h00020;
  localparam logic [18:0] GRB    = 19'h00010;
  localparam logic [18:0] GRC    = 19'h00008;
  localparam logic [18:0] RIN    = 19'h00004;
  localparam logic [18:0] ROUT   = 19'h00002;
  localparam logic [18:0] BAOUT  = 19'h00001;
  localparam logic [18:0] NONE   = 19'h00000;
  localparam logic [18:0] T0S    = PCOUT | MARIN | INCPC | ZIN;

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 27'h0123456};
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] s, input logic [4:0] a,
                     input logic r, input logic il);
    logic [25:0] obs, exp;
    exp = {s, a, r, il};
    obs = {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Zin, bus.Zlowout, bus.Yin,
           bus.MDRin, bus.MDRout, bus.IRin, bus.Read, bus.Write, bus.Cout,
           bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
           bus.alu_op, bus.run, bus.illegal};
    num_cmp++;
    assert (obs === exp) else begin
      num_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch12(input string pfx);
    step(); chk({pfx, "_t1"}, ZLO | PCIN | RD | MDRIN, 5'd0, 1'b1, 1'b0);
    step(); chk({pfx, "_t2"}, MDROUT | IRIN, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    clear = 1'b1;
    bus.IR = 32'h0;
    bus.mem_ready = 1'b1;

    // reset and first fetch step
    step(); chk("clear", NONE, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
    #1 chk("rst_hold", NONE, 5'd0, 1'b0, 1'b0);
    step(); chk("t0_first", T0S, 5'd0, 1'b1, 1'b0);

    // add R3,R7,R10
    bus.IR = {5'b00011, 4'd3, 4'd7, 4'd10, 15'd0};
    fetch12("add");
    step(); chk("add_t3", GRB | ROUT | YIN, 5'd0, 1'b1, 1'b0);
    step(); chk("add_t4", GRC | ROUT | ZIN, 5'b00011, 1'b1, 1'b0);
    step(); chk("add_t5", ZLO | GRA | RIN, 5'd0, 1'b1, 1'b0);
    step(); chk("add_t0", T0S, 5'd0, 1'b1, 1'b0);

    // ld with three wait cycles in T6
    bus.IR = mk(5'b00000);
    fetch12("ld");
    step(); chk("ld_t3", GRB | BAOUT | YIN, 5'd0, 1'b1, 1'b0);
    step(); chk("ld_t4", COUT | ZIN, 5'b00011, 1'b1, 1'b0);
    step(); chk("ld_t5", ZLO | MARIN, 5'd0, 1'b1, 1'b0);
    bus.mem_ready = 1'b0;
    step(); chk("ld_t6_w1", RD, 5'd0, 1'b1, 1'b0);
    step(); chk("ld_t6_w2", RD, 5'd0, 1'b1, 1'b0);
    step(); chk("ld_t6_w3", RD, 5'd0, 1'b1, 1'b0);
    step(); bus.mem_ready = 1'b1;
    #1 chk("ld_t6_rdy", RD | MDRIN, 5'd0, 1'b1, 1'b0);
    step(); chk("ld_t7", MDROUT | GRA | RIN, 5'd0, 1'b1, 1'b0);
    step(); chk("ld_t0", T0S, 5'd0, 1'b1, 1'b0);

    // st with one wait cycle in T7
    bus.IR = mk(5'b00010);
    fetch12("st");
    step(); chk("st_t3", GRB | BAOUT | YIN, 5'd0, 1'b1, 1'b0);
    step(); chk("st_t4", COUT | ZIN, 5'b00011, 1'b1, 1'b0);
    step(); chk("st_t5", ZLO | MARIN, 5'd0, 1'b1, 1'b0);
    step(); chk("st_t6", GRA | ROUT | MDRIN, 5'd0, 1'b1, 1'b0);
    bus.mem_ready = 1'b0;
    step(); chk("st_t7_w", WR, 5'd0, 1'b1, 1'b0);
    step(); chk("st_t7_hold", WR, 5'd0, 1'b1, 1'b0);
    bus.mem_ready = 1'b1;
    step(); chk("st_t0", T0S, 5'd0, 1'b1, 1'b0);

    // halt, then clear restarts fetch
    bus.IR = mk(5'b11011);
    fetch12("halt");
    step(); chk("halt_t3", NONE, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(); chk("halt_idle", NONE, 5'd0, 1'b0, 1'b0);
    end
    clear = 1'b1;
    #1 chk("halt_clear", NONE, 5'd0, 1'b0, 1'b0);
    step(); clear = 1'b0;
    step(); chk("halt_restart", T0S, 5'd0, 1'b1, 1'b0);

    // addi aborted by clear in T4
    bus.IR = mk(5'b01100);
    fetch12("addi");
    step(); chk("addi_t3", GRB | ROUT | YIN, 5'd0, 1'b1, 1'b0);
    step(); chk("addi_t4", COUT | ZIN, 5'b01100, 1'b1, 1'b0);
    clear = 1'b1;
    #1 chk("addi_abort", NONE, 5'd0, 1'b0, 1'b0);
    step(); clear = 1'b0;
    step(); chk("abort_t0", T0S, 5'd0, 1'b1, 1'b0);

    // IR changes during fetch; only the T3 value counts (11111 -> illegal)
    bus.IR = mk(5'b11011);
    step(); chk("ill_t1", ZLO | PCIN | RD | MDRIN, 5'd0, 1'b1, 1'b0);
    bus.IR = mk(5'b11111);
    step(); chk("ill_t2", MDROUT | IRIN, 5'd0, 1'b1, 1'b0);
    step(); chk("ill_t3", NONE, 5'd0, 1'b1, 1'b1);
    step(); chk("ill_t0", T0S, 5'd0, 1'b1, 1'b0);

    // nop with a memory stall in T1
    bus.IR = mk(5'b11010);
    bus.mem_ready = 1'b0;
    step(); chk("nop_t1_w", ZLO | PCIN | RD, 5'd0, 1'b1, 1'b0);
    step(); bus.mem_ready = 1'b1;
    #1 chk("nop_t1_rdy", ZLO | PCIN | RD | MDRIN, 5'd0, 1'b1, 1'b0);
    step(); chk("nop_t2", MDROUT | IRIN, 5'd0, 1'b1, 1'b0);
    step(); chk("nop_t3", NONE, 5'd0, 1'b1, 1'b0);
    step(); chk("nop_t0", T0S, 5'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule
